// File: rtl/set_dispatch.sv
// Job FIFO in front of a single-outstanding set-counting engine. Jobs are issued
// in order, each engine answer (or a timeout) becomes a tagged result record.
module set_dispatch #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_central,
  input  logic [11:0] job_radius,
  input  logic [1:0]  job_mode,
  output logic        set_en,
  output logic [23:0] set_central,
  output logic [11:0] set_radius,
  output logic [1:0]  set_mode,
  input  logic        set_valid,
  input  logic [7:0]  set_candidate,
  output logic        res_valid,
  output logic [7:0]  res_candidate,
  output logic [3:0]  res_tag,
  output logic        res_err,
  input  logic        res_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  // The wait counter only ever holds 0..TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
  } job_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  job_t            mem [FIFO_DEPTH];
  job_t            head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;
  state_t          state;
  logic [3:0]      tag;
  logic [TW-1:0]   cnt;

  assign job_ready = (count != CW'(FIFO_DEPTH));
  assign push      = job_valid && job_ready;
  assign pop       = (state == IDLE) && (count != '0) && !res_valid;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {job_central, job_radius, job_mode};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tag           <= '0;
      cnt           <= '0;
      set_en        <= 1'b0;
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_tag       <= '0;
      res_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          set_central <= head.central;
          set_radius  <= head.radius;
          set_mode    <= head.mode;
          set_en      <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          set_en <= 1'b0;
          cnt    <= '0;
          state  <= WAIT;
        end
        // An answer in the last allowed cycle still beats the timeout.
        WAIT: if (set_valid) begin
          res_valid     <= 1'b1;
          res_candidate <= set_candidate;
          res_err       <= 1'b0;
          res_tag       <= tag;
          tag           <= tag + 4'd1;
          state         <= HOLD;
        end else if (cnt == TW'(TIMEOUT - 1)) begin
          res_valid     <= 1'b1;
          res_candidate <= '0;
          res_err       <= 1'b1;
          res_tag       <= tag;
          tag           <= tag + 4'd1;
          state         <= HOLD;
        end else begin
          cnt <= cnt + TW'(1);
        end
        HOLD: if (res_ready) begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_set_dispatch.sv
// Randomized bench for set_dispatch: a behavioural engine plus job/result
// scoreboards drive and judge the dispatcher.
module tb_set_dispatch;
  localparam int DEPTH = 4;
  localparam int TMO   = 1023;

  logic        clk = 1'b0, rst = 1'b1;
  logic        job_valid, job_ready;
  logic [23:0] job_central;
  logic [11:0] job_radius;
  logic [1:0]  job_mode;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_valid;
  logic [7:0]  set_candidate;
  logic        res_valid;
  logic [7:0]  res_candidate;
  logic [3:0]  res_tag;
  logic        res_err;
  logic        res_ready;

  set_dispatch #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_central(job_central), .job_radius(job_radius), .job_mode(job_mode),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
    .set_valid(set_valid), .set_candidate(set_candidate),
    .res_valid(res_valid), .res_candidate(res_candidate), .res_tag(res_tag), .res_err(res_err),
    .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cand;
    logic [3:0] tag;
    logic       err;
  } res_t;

  int          n_chk = 0, n_err = 0, cyc = 0;
  logic [37:0] exp_jobs[$];
  res_t        exp_res[$];
  res_t        cur;
  bit          have_cur = 0;

  int          resp_left = 0, dly_min = 1, dly_max = 8, fixed_cand = -1;
  int          issue_cyc = 0, last_sv = -100, n_issue = 0, rr_mode = 1;
  bit          silent = 0, late_pulse = 0, aborted = 0;
  logic [7:0]  pend_cand;
  logic [37:0] cur_job;
  logic [3:0]  tag_m = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural engine: answers each set_en after a chosen delay, or never.
  initial begin
    res_t e;
    set_valid = 0; set_candidate = 0;
    forever begin
      @(negedge clk);
      set_valid = 0;
      if (late_pulse) begin
        set_valid = 1; set_candidate = 8'h77; late_pulse = 0;
      end else if (resp_left > 0) begin
        resp_left--;
        if (resp_left == 0) begin
          if (!aborted) chk("set_stable", {set_central, set_radius, set_mode}, cur_job);
          aborted = 0;
          set_valid = 1; set_candidate = pend_cand; last_sv = cyc;
        end
      end
      if (set_en) begin
        n_issue++; issue_cyc = cyc;
        chk("spacing", (cyc - last_sv) >= 2, 1);
        chk("en_in_hold", res_valid, 0);
        if (exp_jobs.size() == 0) chk("unexp_issue", 1, 0);
        else begin
          cur_job = exp_jobs.pop_front();
          chk("issue_job", {set_central, set_radius, set_mode}, cur_job);
        end
        pend_cand = (fixed_cand >= 0) ? 8'(fixed_cand) : 8'($urandom_range(0, 255));
        e.tag = tag_m; tag_m = tag_m + 4'd1;
        if (silent) begin e.cand = 0; e.err = 1; end
        else begin
          e.cand = pend_cand; e.err = 0;
          resp_left = $urandom_range(dly_min, dly_max);
        end
        exp_res.push_back(e);
      end
    end
  end

  // Result scoreboard: first sighting compares, later cycles check stability.
  initial forever begin
    @(negedge clk);
    if (!rst && res_valid) begin
      if (!have_cur) begin
        if (exp_res.size() == 0) chk("unexp_result", 1, 0);
        else begin
          cur = exp_res.pop_front(); have_cur = 1;
          chk("res_cand", res_candidate, cur.cand);
          chk("res_tag", res_tag, cur.tag);
          chk("res_err", res_err, cur.err);
          if (cur.err) chk("tmo_latency", cyc - issue_cyc, TMO + 1);
        end
      end else begin
        chk("res_hold", {res_candidate, res_tag, res_err}, {cur.cand, cur.tag, cur.err});
      end
      if (res_ready) have_cur = 0;
    end
  end

  initial begin
    res_ready = 0;
    forever begin
      @(posedge clk); #1;
      res_ready = (rr_mode == 2) ? ($urandom_range(0, 3) != 0) : (rr_mode == 1);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int i = 0;
    job_valid = 1; job_central = c; job_radius = r; job_mode = m;
    do begin @(negedge clk); i++; end while (!job_ready && i < 3000);
    chk("push_wait", job_ready, 1);
    exp_jobs.push_back({c, r, m});
    @(posedge clk); #1;
    job_valid = 0;
  endtask

  task automatic push_rand();
    push_job(24'($urandom), 12'($urandom), 2'($urandom));
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while (i < budget && (exp_jobs.size() != 0 || exp_res.size() != 0 || have_cur ||
                          res_valid || resp_left != 0)) begin
      @(negedge clk); i++;
    end
    chk("drain", i < budget, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_res(input int budget);
    int i = 0;
    while (i < budget && !res_valid) begin @(negedge clk); i++; end
    chk("res_seen", res_valid, 1);
  endtask

  initial begin
    int k, ens, base;
    job_valid = 0; job_central = 0; job_radius = 0; job_mode = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {set_en, res_valid, res_err, res_tag, res_candidate, set_central, set_radius, set_mode}, 0);
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("rst_ready", job_ready, 1);
    @(posedge clk); #1;

    // Single directed job answered after 320 cycles.
    rr_mode = 1; fixed_cand = 8'h1D; dly_min = 320; dly_max = 320;
    push_job(24'h443355, 12'h333, 2'd0);
    wait_drain(1000);
    chk("single_issue_cnt", n_issue, 1);
    fixed_cand = -1;

    // Five back-to-back jobs with a slow first answer: FIFO fills.
    dly_min = 100; dly_max = 100;
    repeat (5) push_rand();
    @(negedge clk);
    chk("full_ready", job_ready, 0);
    dly_min = 1; dly_max = 8; rr_mode = 2;
    @(posedge clk); #1;
    wait_drain(2000);

    // Back-pressure: result held 50 cycles, nothing issued meanwhile.
    @(negedge clk); rr_mode = 0;
    @(posedge clk); #1;
    push_rand(); push_rand();
    wait_res(200);
    ens = 0;
    repeat (50) begin @(negedge clk); if (set_en) ens++; end
    chk("hold_no_issue", ens, 0);
    rr_mode = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!set_en && k < 10);
    chk("reissue_lat", k, 3);
    @(posedge clk); #1;
    wait_drain(200);

    // Engine never answers; a late answer is ignored.
    silent = 1; @(negedge clk); rr_mode = 0;
    @(posedge clk); #1;
    push_rand();
    wait_res(TMO + 100);
    late_pulse = 1;
    repeat (4) @(negedge clk);
    silent = 0; rr_mode = 1;
    @(posedge clk); #1;
    wait_drain(100);

    // Reset while waiting on the engine with three jobs queued.
    dly_min = 200; dly_max = 200;
    repeat (4) push_rand();
    repeat (20) @(posedge clk);
    #1;
    base = n_issue;
    rst = 1; aborted = 1;
    exp_jobs.delete(); exp_res.delete(); have_cur = 0; tag_m = 0;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("mid_rst_outs", {set_en, res_valid, res_err, res_tag, res_candidate, set_central, set_radius, set_mode}, 0);
    chk("mid_rst_ready", job_ready, 1);
    repeat (250) @(negedge clk);
    chk("post_rst_issue", n_issue, base);
    chk("post_rst_resp_done", resp_left, 0);
    @(posedge clk); #1;

    // Seventeen jobs: tags run 0..15 then wrap to 0.
    dly_min = 1; dly_max = 6; rr_mode = 2;
    repeat (17) push_rand();
    wait_drain(3000);
    chk("tag_wrap_model", tag_m, 4'd1);

    // Random traffic with idle gaps.
    dly_min = 1; dly_max = 40;
    repeat (20) begin
      push_rand();
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
    end
    wait_drain(5000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
